// File: rtl/tb_doutb_ctrl_pkg.sv
// Shared encodings for the TB port-B read sequencer: mode select fields,
// fixed issue count of the B_cache transpose/inv modes and FSM states.
package tb_doutb_ctrl_pkg;

    localparam logic       SEL_B        = 1'b0;
    localparam logic       SEL_BC       = 1'b1;

    localparam logic [1:0] DIR_IDLE     = 2'b00;
    localparam logic [1:0] DIR_POS      = 2'b01;
    localparam logic [1:0] DIR_NEG      = 2'b10;
    localparam logic [1:0] DIR_NEW      = 2'b11;

    localparam logic [1:0] BC_IDLE      = 2'b00;
    localparam logic [1:0] BC_TRANSFER  = 2'b01;
    localparam logic [1:0] BC_TRANSPOSE = 2'b10;
    localparam logic [1:0] BC_INV       = 2'b11;

    localparam int FIXED_ISSUE_N = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_DRAIN = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    // Transpose and inv read an 8-row block with two skipped slots.
    function automatic logic fixed8_mode(input logic bank, input logic [1:0] sub);
        return (bank == SEL_BC) && ((sub == BC_TRANSPOSE) || (sub == BC_INV));
    endfunction

endpackage

// File: rtl/tb_rd_align_pipe.sv
// Fixed-depth shift pipeline with a valid bit; delays side information so it
// lines up with the data returned by the TB read port.
module tb_rd_align_pipe #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         vld_in,
    input  logic [W-1:0] din,
    output logic         vld_out,
    output logic [W-1:0] dout
);

    logic [DEPTH-1:0] vld_r;
    logic [W-1:0]     data_r [DEPTH];

    // Stage 0 captures the input; every later stage takes its predecessor.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                vld_r[i]  <= 1'b0;
                data_r[i] <= {W{1'b0}};
            end
        end else begin
            vld_r[0]  <= vld_in;
            data_r[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                vld_r[i]  <= vld_r[i-1];
                data_r[i] <= data_r[i-1];
            end
        end
    end

    assign vld_out = vld_r[DEPTH-1];
    assign dout    = data_r[DEPTH-1];

endmodule

// File: rtl/tb_doutb_ctrl.sv
// TB port-B read sequencer: accepts one command, issues the row reads for the
// selected B / B_cache mode and emits mapper selects aligned to TB_doutb.
module tb_doutb_ctrl
    import tb_doutb_ctrl_pkg::*;
#(
    parameter int TB_AW           = 10,
    parameter int SEQ_CNT_DW      = 5,
    parameter int TB_DOUTB_SEL_DW = 3,
    parameter int RD_LAT          = 2
) (
    input  logic                       clk,
    input  logic                       sys_rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [TB_DOUTB_SEL_DW-1:0] cmd_sel,
    input  logic [TB_AW-1:0]           cmd_base_addr,
    input  logic [SEQ_CNT_DW-1:0]      cmd_len,
    input  logic                       cmd_l_k_0,
    output logic                       TB_enb,
    output logic [TB_AW-1:0]           TB_addrb,
    output logic [TB_DOUTB_SEL_DW-1:0] TB_doutb_sel,
    output logic [SEQ_CNT_DW-1:0]      seq_cnt_dout_sel,
    output logic                       l_k_0,
    output logic                       busy,
    output logic                       done
);

    localparam int SW = TB_DOUTB_SEL_DW;
    localparam int CW = SEQ_CNT_DW;
    localparam int PW = SW + CW + 1;

    state_t          state_r, state_s;
    logic [SW-1:0]   sel_r, eff_sel_s;
    logic [TB_AW-1:0] base_r, eff_base_s;
    logic [CW-1:0]   n_r, cmd_n_s;
    logic [CW-1:0]   seq_r, seq_s, off_s;
    logic            lk_r;
    logic            accept_s, issue_s, tp_s, gap_s, enb_s;
    logic [TB_AW-1:0] addr_s;
    logic            enb_r;
    logic [TB_AW-1:0] addr_r;
    logic            iss_vld_r;
    logic [CW-1:0]   iss_seq_r;
    logic            pipe_vld_s;
    logic [PW-1:0]   pipe_dout_s;

    assign cmd_ready = (state_r == ST_IDLE) && !sys_rst;
    assign accept_s  = cmd_valid && cmd_ready;
    assign busy      = (state_r != ST_IDLE);
    assign done      = (state_r == ST_DONE);
    assign TB_enb    = enb_r;
    assign TB_addrb  = addr_r;

    // Number of rows a freshly offered command will read.
    always_comb begin
        cmd_n_s = {CW{1'b0}};
        if (cmd_sel[2] == SEL_B) begin
            case (cmd_sel[1:0])
                DIR_POS, DIR_NEG, DIR_NEW: cmd_n_s = cmd_len;
                DIR_IDLE:                  cmd_n_s = {CW{1'b0}};
                default:                   cmd_n_s = {CW{1'b0}};
            endcase
        end else begin
            case (cmd_sel[1:0])
                BC_TRANSFER:          cmd_n_s = cmd_len;
                BC_TRANSPOSE, BC_INV: cmd_n_s = CW'(FIXED_ISSUE_N);
                BC_IDLE:              cmd_n_s = {CW{1'b0}};
                default:              cmd_n_s = {CW{1'b0}};
            endcase
        end
    end

    // Next state; seq_r doubles as the drain counter outside ISSUE.
    always_comb begin
        state_s = state_r;
        seq_s   = seq_r;
        issue_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    seq_s = {CW{1'b0}};
                    if (cmd_sel[1:0] == DIR_IDLE) begin
                        state_s = ST_DONE;
                    end else if (cmd_n_s == {CW{1'b0}}) begin
                        state_s = ST_DRAIN;
                    end else begin
                        state_s = ST_ISSUE;
                        issue_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (seq_r == n_r - CW'(1'b1)) begin
                    state_s = ST_DRAIN;
                    seq_s   = {CW{1'b0}};
                end else begin
                    seq_s   = seq_r + CW'(1'b1);
                    issue_s = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (seq_r == CW'(RD_LAT - 1)) begin
                    state_s = ST_DONE;
                    seq_s   = {CW{1'b0}};
                end else begin
                    seq_s   = seq_r + CW'(1'b1);
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                seq_s   = {CW{1'b0}};
            end
            default: begin
                state_s = ST_IDLE;
                seq_s   = {CW{1'b0}};
            end
        endcase
    end

    // Read address for the next cycle; the acceptance cycle uses the live command.
    always_comb begin
        if (accept_s) begin
            eff_sel_s  = cmd_sel;
            eff_base_s = cmd_base_addr;
        end else begin
            eff_sel_s  = sel_r;
            eff_base_s = base_r;
        end
        tp_s  = fixed8_mode(eff_sel_s[2], eff_sel_s[1:0]);
        gap_s = tp_s && ((seq_s == {CW{1'b0}}) || (seq_s == CW'(3'd4)));
        if (!tp_s) begin
            off_s = seq_s;
        end else if (seq_s <= CW'(2'd3)) begin
            off_s = seq_s - CW'(1'b1);
        end else begin
            off_s = seq_s - CW'(2'd2);
        end
        enb_s = issue_s && !gap_s;
        if (enb_s) begin
            addr_s = eff_base_s + TB_AW'(off_s);
        end else begin
            addr_s = addr_r;
        end
    end

    // Control state, command latch and registered read-port outputs.
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_r   <= ST_IDLE;
            seq_r     <= {CW{1'b0}};
            sel_r     <= {SW{1'b0}};
            base_r    <= {TB_AW{1'b0}};
            n_r       <= {CW{1'b0}};
            lk_r      <= 1'b0;
            enb_r     <= 1'b0;
            addr_r    <= {TB_AW{1'b0}};
            iss_vld_r <= 1'b0;
            iss_seq_r <= {CW{1'b0}};
        end else begin
            state_r   <= state_s;
            seq_r     <= seq_s;
            enb_r     <= enb_s;
            addr_r    <= addr_s;
            iss_vld_r <= issue_s;
            iss_seq_r <= issue_s ? seq_s : {CW{1'b0}};
            if (accept_s) begin
                sel_r  <= cmd_sel;
                base_r <= cmd_base_addr;
                n_r    <= cmd_n_s;
                lk_r   <= cmd_l_k_0;
            end
        end
    end

    tb_rd_align_pipe #(
        .W     (PW),
        .DEPTH (RD_LAT)
    ) u_align (
        .clk     (clk),
        .rst     (sys_rst),
        .vld_in  (iss_vld_r),
        .din     ({sel_r, iss_seq_r, lk_r}),
        .vld_out (pipe_vld_s),
        .dout    (pipe_dout_s)
    );

    assign TB_doutb_sel     = pipe_vld_s ? pipe_dout_s[PW-1 -: SW] : {SW{1'b0}};
    assign seq_cnt_dout_sel = pipe_vld_s ? pipe_dout_s[CW:1] : {CW{1'b0}};
    assign l_k_0            = pipe_dout_s[0];

endmodule

// File: tb/tb_tb_doutb_ctrl.sv
// Self-checking bench for tb_doutb_ctrl: scoreboard queues of expected reads and
// aligned selects, filled when a command is driven and drained by a monitor.
module tb_tb_doutb_ctrl;

    localparam int TB_AW   = 10;
    localparam int CW      = 5;
    localparam int SW      = 3;
    localparam int RD_LAT  = 2;

    logic             clk = 1'b0;
    logic             sys_rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [SW-1:0]    cmd_sel;
    logic [TB_AW-1:0] cmd_base_addr;
    logic [CW-1:0]    cmd_len;
    logic             cmd_l_k_0;
    logic             TB_enb;
    logic [TB_AW-1:0] TB_addrb;
    logic [SW-1:0]    TB_doutb_sel;
    logic [CW-1:0]    seq_cnt_dout_sel;
    logic             l_k_0;
    logic             busy;
    logic             done;

    tb_doutb_ctrl #(
        .TB_AW           (TB_AW),
        .SEQ_CNT_DW      (CW),
        .TB_DOUTB_SEL_DW (SW),
        .RD_LAT          (RD_LAT)
    ) dut (
        .clk              (clk),
        .sys_rst          (sys_rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_sel          (cmd_sel),
        .cmd_base_addr    (cmd_base_addr),
        .cmd_len          (cmd_len),
        .cmd_l_k_0        (cmd_l_k_0),
        .TB_enb           (TB_enb),
        .TB_addrb         (TB_addrb),
        .TB_doutb_sel     (TB_doutb_sel),
        .seq_cnt_dout_sel (seq_cnt_dout_sel),
        .l_k_0            (l_k_0),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int               cyc;
        logic [TB_AW-1:0] addr;
    } rd_t;

    typedef struct {
        int            cyc;
        logic [SW-1:0] sel;
        logic [CW-1:0] seq;
        logic          lk;
    } al_t;

    rd_t rd_q[$];
    al_t al_q[$];
    int  tests_run = 0;
    int  fail_cnt  = 0;

    // Command table for single-command scenarios (includes wrap and empty cases).
    localparam int NCMD = 8;
    logic [SW-1:0]    t_sel  [NCMD] = '{3'b001, 3'b110, 3'b010, 3'b101, 3'b111, 3'b011, 3'b001, 3'b100};
    logic [TB_AW-1:0] t_base [NCMD] = '{10'd10, 10'd20, 10'd1022, 10'd500, 10'd100, 10'd1020, 10'd5, 10'd7};
    logic [CW-1:0]    t_len  [NCMD] = '{5'd4, 5'd0, 5'd4, 5'd3, 5'd3, 5'd7, 5'd0, 5'd9};
    logic             t_lk   [NCMD] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    // Reference model: expected reads are base + read index, one per non-gap slot.
    task automatic push_exp(input logic [SW-1:0] sel, input logic [TB_AW-1:0] base,
                            input logic [CW-1:0] len, input logic lk, input int acc,
                            output int done_cyc);
        int n;
        int k;
        bit tp;
        tp = sel[2] && sel[1];
        if (sel[1:0] == 2'b00) n = 0;
        else if (tp)           n = 8;
        else                   n = int'(len);
        k = 0;
        for (int s = 0; s < n; s++) begin
            if (!(tp && (s == 0 || s == 4))) begin
                rd_q.push_back('{acc + 1 + s, base + TB_AW'(k)});
                k++;
            end
            al_q.push_back('{acc + 1 + s + RD_LAT, sel, CW'(s), lk});
        end
        done_cyc = (sel[1:0] == 2'b00) ? acc + 1 : acc + n + RD_LAT + 1;
    endtask

    task automatic drive(input logic [SW-1:0] sel, input logic [TB_AW-1:0] base,
                         input logic [CW-1:0] len, input logic lk);
        cmd_valid     = 1'b1;
        cmd_sel       = sel;
        cmd_base_addr = base;
        cmd_len       = len;
        cmd_l_k_0     = lk;
    endtask

    // Monitor: pop and compare whenever a read or an aligned select appears.
    always @(negedge clk) begin
        rd_t r;
        al_t a;
        if (TB_enb === 1'b1) begin
            tests_run++;
            if (rd_q.size() == 0) begin
                fail_cnt++;
                $display("FAIL unexpected_read: got addr %0d at cycle %0d, required no read", TB_addrb, cyc);
            end else begin
                r = rd_q.pop_front();
                if (r.cyc != cyc || TB_addrb !== r.addr) begin
                    fail_cnt++;
                    $display("FAIL read: got addr %0d at cycle %0d, required addr %0d at cycle %0d",
                             TB_addrb, cyc, r.addr, r.cyc);
                end
            end
        end
        if (TB_doutb_sel !== {SW{1'b0}}) begin
            tests_run++;
            if (al_q.size() == 0) begin
                fail_cnt++;
                $display("FAIL unexpected_sel: got sel %b seq %0d at cycle %0d, required none",
                         TB_doutb_sel, seq_cnt_dout_sel, cyc);
            end else begin
                a = al_q.pop_front();
                if (a.cyc != cyc || TB_doutb_sel !== a.sel || seq_cnt_dout_sel !== a.seq || l_k_0 !== a.lk) begin
                    fail_cnt++;
                    $display("FAIL aligned: got cyc %0d sel %b seq %0d lk %b, required cyc %0d sel %b seq %0d lk %b",
                             cyc, TB_doutb_sel, seq_cnt_dout_sel, l_k_0, a.cyc, a.sel, a.seq, a.lk);
                end
            end
        end else begin
            tests_run++;
            if (seq_cnt_dout_sel !== {CW{1'b0}}) begin
                fail_cnt++;
                $display("FAIL idle_seq: got seq %0d with sel 0 at cycle %0d, required 0", seq_cnt_dout_sel, cyc);
            end
        end
    end

    task automatic test_reset();
        sys_rst = 1'b1;
        cmd_valid = 1'b0; cmd_sel = '0; cmd_base_addr = '0; cmd_len = '0; cmd_l_k_0 = 1'b0;
        #2;
        tests_run++;
        if ({TB_enb, TB_addrb, TB_doutb_sel, seq_cnt_dout_sel, l_k_0, busy, done, cmd_ready} !== '0) begin
            fail_cnt++;
            $display("FAIL reset_state: got enb %b addr %0d sel %b seq %0d lk %b busy %b done %b ready %b, required all 0",
                     TB_enb, TB_addrb, TB_doutb_sel, seq_cnt_dout_sel, l_k_0, busy, done, cmd_ready);
        end
        @(negedge clk);
        sys_rst = 1'b0;
        #1;
        tests_run++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            fail_cnt++;
            $display("FAIL reset_release: got ready %b busy %b, required ready 1 busy 0", cmd_ready, busy);
        end
    endtask

    task automatic test_single_cmds();
        int acc;
        int dc;
        for (int i = 0; i < NCMD; i++) begin
            @(negedge clk);
            acc = cyc;
            tests_run++;
            if (cmd_ready !== 1'b1) begin
                fail_cnt++;
                $display("FAIL ready_idle[%0d]: got %b, required 1", i, cmd_ready);
            end
            drive(t_sel[i], t_base[i], t_len[i], t_lk[i]);
            push_exp(t_sel[i], t_base[i], t_len[i], t_lk[i], acc, dc);
            @(negedge clk);
            cmd_valid = 1'b0;
            tests_run++;
            if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
                fail_cnt++;
                $display("FAIL busy_cycle1[%0d]: got busy %b ready %b, required busy 1 ready 0", i, busy, cmd_ready);
            end
            for (int w = 0; w < 64 && done !== 1'b1; w++) @(negedge clk);
            tests_run++;
            if (done !== 1'b1 || cyc != dc) begin
                fail_cnt++;
                $display("FAIL done_cycle[%0d]: got done %b at cycle %0d, required done 1 at cycle %0d", i, done, cyc, dc);
            end
            @(negedge clk);
            tests_run++;
            if (cmd_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
                fail_cnt++;
                $display("FAIL ready_return[%0d]: got ready %b done %b busy %b, required 1 0 0", i, cmd_ready, done, busy);
            end
            tests_run++;
            if (rd_q.size() != 0 || al_q.size() != 0) begin
                fail_cnt++;
                $display("FAIL missing_out[%0d]: got %0d reads %0d selects pending, required 0 0", i, rd_q.size(), al_q.size());
            end
        end
    endtask

    task automatic test_reset_mid();
        int acc;
        int dc;
        @(negedge clk);
        acc = cyc;
        drive(3'b001, 10'd300, 5'd6, 1'b1);
        push_exp(3'b001, 10'd300, 5'd6, 1'b1, acc, dc);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (TB_addrb !== 10'd302 || TB_enb !== 1'b1) begin
            fail_cnt++;
            $display("FAIL mid_seq2: got enb %b addr %0d, required 1 302", TB_enb, TB_addrb);
        end
        #2;
        sys_rst = 1'b1;
        #1;
        tests_run++;
        if ({TB_enb, TB_addrb, TB_doutb_sel, seq_cnt_dout_sel, l_k_0, busy, done, cmd_ready} !== '0) begin
            fail_cnt++;
            $display("FAIL mid_reset: got enb %b addr %0d sel %b seq %0d lk %b busy %b done %b ready %b, required all 0",
                     TB_enb, TB_addrb, TB_doutb_sel, seq_cnt_dout_sel, l_k_0, busy, done, cmd_ready);
        end
        rd_q.delete();
        al_q.delete();
        @(negedge clk);
        sys_rst = 1'b0;
        #1;
        tests_run++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            fail_cnt++;
            $display("FAIL mid_release: got ready %b busy %b, required 1 0", cmd_ready, busy);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            tests_run++;
            if (done !== 1'b0) begin
                fail_cnt++;
                $display("FAIL mid_no_done: got done %b at cycle %0d, required 0", done, cyc);
            end
        end
    endtask

    task automatic test_back_to_back();
        int a1;
        int a2;
        int d1;
        int d2;
        @(negedge clk);
        a1 = cyc;
        drive(3'b001, 10'd50, 5'd3, 1'b0);
        push_exp(3'b001, 10'd50, 5'd3, 1'b0, a1, d1);
        a2 = d1 + 1;
        @(negedge clk);
        drive(3'b011, 10'd200, 5'd2, 1'b1);
        push_exp(3'b011, 10'd200, 5'd2, 1'b1, a2, d2);
        while (cyc < a2 && cyc < a1 + 64) begin
            tests_run++;
            if (cmd_ready !== 1'b0 || done !== logic'(cyc == d1)) begin
                fail_cnt++;
                $display("FAIL b2b_hold: got ready %b done %b at cycle %0d, required ready 0 done %b",
                         cmd_ready, done, cyc, cyc == d1);
            end
            @(negedge clk);
        end
        tests_run++;
        if (cmd_ready !== 1'b1 || cyc != a2) begin
            fail_cnt++;
            $display("FAIL b2b_accept: got ready %b at cycle %0d, required 1 at cycle %0d", cmd_ready, cyc, a2);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int w = 0; w < 64 && done !== 1'b1; w++) @(negedge clk);
        tests_run++;
        if (done !== 1'b1 || cyc != d2) begin
            fail_cnt++;
            $display("FAIL b2b_done: got done %b at cycle %0d, required 1 at cycle %0d", done, cyc, d2);
        end
        @(negedge clk);
        tests_run++;
        if (rd_q.size() != 0 || al_q.size() != 0 || cmd_ready !== 1'b1) begin
            fail_cnt++;
            $display("FAIL b2b_end: got %0d reads %0d selects pending ready %b, required 0 0 1",
                     rd_q.size(), al_q.size(), cmd_ready);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_cmds();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
